shift_sub_divider: RTL and testbench

//   Sequential signed (two's complement) N-bit divider, the inverse counterpart of the add/shift

---
 rtl/shift_sub_divider.sv | 142 ++++++++++++++
 tb/tb_shift_sub_divider.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sub_divider.sv
// Sequential signed restoring divider: one shift/subtract step per clock on the
// operand magnitudes, with the signs applied to quotient and remainder at the end.
module shift_sub_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         ready,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  divisor_q;
    logic [N-1:0]  rem_q;
    logic          signA_q;
    logic          signQ_q;
    logic          ovfPend_q;
    logic          zeroPend_q;
    logic [N-1:0]  qOut_q;
    logic [N-1:0]  rOut_q;
    logic          ready_q;
    logic          dbz_q;
    logic          ovf_q;

    logic [N-1:0]  absA_d;
    logic [N-1:0]  absB_d;
    logic          bZero_d;
    logic          ovfCase_d;
    logic [N:0]    shifted_d;
    logic [N:0]    trial_d;
    logic [N-1:0]  remNext_d;
    logic [N-1:0]  quoNext_d;
    logic [N-1:0]  quoSigned_d;
    logic [N-1:0]  remSigned_d;
    logic [N-1:0]  dividend_d;

    // The held remainder is always below the divisor magnitude (at most 2^(N-1)),
    // so it fits in N bits; only the shifted trial value needs the extra bit.
    always_comb begin
        absA_d      = a[N-1] ? N'(-a) : a;
        absB_d      = b[N-1] ? N'(-b) : b;
        bZero_d     = (b == '0);
        ovfCase_d   = (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
        shifted_d   = {rem_q, quo_q[N-1]};
        trial_d     = shifted_d - {1'b0, divisor_q};
        remNext_d   = trial_d[N] ? shifted_d[N-1:0] : trial_d[N-1:0];
        quoNext_d   = {quo_q[N-2:0], ~trial_d[N]};
        quoSigned_d = signQ_q ? N'(-quo_q) : quo_q;
        remSigned_d = signA_q ? N'(-rem_q) : rem_q;
        dividend_d  = signA_q ? N'(-quo_q) : quo_q;
    end

    // Controller and datapath; start wins over every state so an in-flight
    // division is simply discarded and the outputs keep the last result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            signA_q    <= 1'b0;
            signQ_q    <= 1'b0;
            ovfPend_q  <= 1'b0;
            zeroPend_q <= 1'b0;
            qOut_q     <= '0;
            rOut_q     <= '0;
            ready_q    <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (start) begin
            signA_q    <= a[N-1];
            signQ_q    <= a[N-1] ^ b[N-1];
            quo_q      <= absA_d;
            divisor_q  <= absB_d;
            rem_q      <= '0;
            count_q    <= CW'(N);
            ovfPend_q  <= ovfCase_d;
            zeroPend_q <= bZero_d;
            ready_q    <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            state_q    <= bZero_d ? DONE : CALC;
        end else begin
            case (state_q)
                CALC: begin
                    rem_q   <= remNext_d;
                    quo_q   <= quoNext_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    qOut_q  <= quoSigned_d;
                    rOut_q  <= ovfPend_q ? '0 : remSigned_d;
                    ovf_q   <= ovfPend_q;
                    dbz_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    // A zero divisor skips CALC; its result is published on the first DONE edge.
                    if (zeroPend_q) begin
                        qOut_q     <= '1;
                        rOut_q     <= dividend_d;
                        dbz_q      <= 1'b1;
                        ovf_q      <= 1'b0;
                        ready_q    <= 1'b1;
                        zeroPend_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign q           = qOut_q;
    assign r           = rOut_q;
    assign ready       = ready_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Bench for shift_sub_divider: directed table, abort/reset/hold sequences, and
// exhaustive plus randomized operands checked against an integer-division model.
module tb_shift_sub_divider;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         ready;
    logic         div_by_zero;
    logic         overflow;

    int nCompared = 0;
    int nMismatched = 0;

    shift_sub_divider #(.N(N)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .a(a),
        .b(b),
        .q(q),
        .r(r),
        .ready(ready),
        .div_by_zero(div_by_zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] expQ;
        logic [N-1:0] expR;
        logic         expDbz;
        logic         expOvf;
        int           expLat;
    } vec_t;

    vec_t vecs[8];

    // Reference: plain signed integer division, returns {q, r, dbz, ovf}.
    function automatic logic [2*N+1:0] model(input logic [N-1:0] av, input logic [N-1:0] bv);
        int ai;
        int bi;
        int qi;
        int ri;
        logic ovf;
        logic [N-1:0] qv;
        logic [N-1:0] rv;
        ai = $signed(av);
        bi = $signed(bv);
        if (bi == 0) begin
            return {{N{1'b1}}, av, 1'b1, 1'b0};
        end
        qi = ai / bi;
        ri = ai % bi;
        ovf = (ai == -(1 << (N - 1))) && (bi == -1);
        if (ovf) begin
            qi = -(1 << (N - 1));
            ri = 0;
        end
        qv = qi[N-1:0];
        rv = ri[N-1:0];
        return {qv, rv, 1'b0, ovf};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the start edge until ready; bounded.
    task automatic waitReady(output int lat);
        lat = 0;
        while (!ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!ready) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL ready_timeout: got ready=0 after %0d edges expected ready=1", lat);
        end
    endtask

    task automatic checkResult(input string name, input logic [N-1:0] av, input logic [N-1:0] bv);
        logic [2*N+1:0] m;
        m = model(av, bv);
        nCompared++;
        if ({q, r, div_by_zero, overflow, ready} !== {m, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL %s a=%h b=%h: got q=%h r=%h dbz=%b ovf=%b rdy=%b expected q=%h r=%h dbz=%b ovf=%b rdy=1",
                     name, av, bv, q, r, div_by_zero, overflow, ready,
                     m[2*N+1:N+2], m[N+1:2], m[1], m[0]);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        logic sawStale;
        logic sawReady;
        logic [N-1:0] lastA;
        logic [N-1:0] lastB;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        vecs[0] = '{4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0, 5};
        vecs[1] = '{4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0, 5};
        vecs[2] = '{4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0, 5};
        vecs[3] = '{4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1, 5};
        vecs[4] = '{4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1, 1'b0, 1};
        vecs[5] = '{4'b0011, 4'b0101, 4'b0000, 4'b0011, 1'b0, 1'b0, 5};
        vecs[6] = '{4'b1010, 4'b0100, 4'b1111, 4'b1110, 1'b0, 1'b0, 5};
        vecs[7] = '{4'b1000, 4'b0011, 4'b1110, 4'b1110, 1'b0, 1'b0, 5};

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_held", 32'({q, r, ready, div_by_zero, overflow}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_idle", 32'({q, r, ready, div_by_zero, overflow}), 32'd0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d_ready_cleared", i), 32'(ready), 32'd0);
            waitReady(lat);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
            checkOutput($sformatf("vec%0d_result", i),
                        32'({q, r, div_by_zero, overflow, ready}),
                        32'({vecs[i].expQ, vecs[i].expR, vecs[i].expDbz, vecs[i].expOvf, 1'b1}));
            repeat (3) @(negedge clk);
            checkOutput($sformatf("vec%0d_hold", i),
                        32'({q, r, div_by_zero, overflow, ready}),
                        32'({vecs[i].expQ, vecs[i].expR, vecs[i].expDbz, vecs[i].expOvf, 1'b1}));
        end

        // Abort: 7/3 restarted at the second CALC edge with -6/4
        applyStimulus(4'b0111, 4'b0011);
        @(negedge clk);
        a = 4'b1010;
        b = 4'b0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sawStale = 1'b0;
        lat = 0;
        while (!ready && lat < 40) begin
            if (q == 4'b0010 && r == 4'b0001) sawStale = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (q == 4'b0010 && r == 4'b0001) sawStale = 1'b1;
        checkOutput("abort_no_stale", 32'(sawStale), 32'd0);
        checkOutput("abort_latency", 32'(lat), 32'd5);
        checkOutput("abort_result", 32'({q, r, div_by_zero, overflow, ready}),
                    32'({4'b1111, 4'b1110, 1'b0, 1'b0, 1'b1}));

        // Reset mid-CALC
        applyStimulus(4'b0111, 4'b0010);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midcalc_reset", 32'({q, r, ready, div_by_zero, overflow}), 32'd0);
        reset = 1'b0;
        sawReady = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ready) sawReady = 1'b1;
        end
        checkOutput("midcalc_reset_no_ready", 32'(sawReady), 32'd0);

        // start held high: reload every edge, ready never rises
        sawReady = 1'b0;
        lastA = '0;
        lastB = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready) sawReady = 1'b1;
            lastA = 4'($urandom);
            lastB = 4'($urandom_range(1, 7));
            a = lastA;
            b = lastB;
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        if (ready) sawReady = 1'b1;
        checkOutput("held_start_no_ready", 32'(sawReady), 32'd0);
        waitReady(lat);
        checkOutput("held_start_latency", 32'(lat), 32'(N + 1));
        checkResult("held_start_result", lastA, lastB);

        // Operands changing after the start edge are ignored
        applyStimulus(4'b1011, 4'b0010);
        a = 4'b0110;
        b = 4'b1101;
        waitReady(lat);
        checkResult("operand_change", 4'b1011, 4'b0010);

        // Exhaustive operand pairs
        for (int ai = 0; ai < (1 << N); ai++) begin
            for (int bi = 0; bi < (1 << N); bi++) begin
                applyStimulus(ai[N-1:0], bi[N-1:0]);
                waitReady(lat);
                checkResult("exhaustive", ai[N-1:0], bi[N-1:0]);
            end
        end

        // Random operands with occasional restarts at random points
        for (int i = 0; i < 300; i++) begin
            ra = 4'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : 4'($urandom);
            applyStimulus(ra, rb);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
                ra = 4'($urandom);
                rb = 4'($urandom);
                applyStimulus(ra, rb);
            end
            waitReady(lat);
            checkOutput("random_latency", 32'(lat), (rb == '0) ? 32'd1 : 32'(N + 1));
            checkResult("random", ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
